// File: rtl/sfifo_mem_ctrl.sv
// Single-clock FIFO: block-RAM storage with pointer/count control, standard or FWFT output.
// Optional sticky overflow/underflow detection is built only when SFIFO_ERR_FLAG_EN is defined.
module sfifo_mem_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wr_en_i,
   input  logic [DATA_WIDTH-1:0]         wr_data_i,
   output logic                          full_o,
   output logic                          afull_o,
   input  logic                          rd_en_i,
   output logic [DATA_WIDTH-1:0]         rd_data_o,
   output logic                          empty_o,
   output logic                          aempty_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overflow_o,
   output logic                          underflow_o
);

   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [ADDR_WIDTH:0]   cnt_t;

   localparam cnt_t DEPTH_LVL  = cnt_t'(FIFO_DEPTH);
   localparam cnt_t AFULL_LVL  = cnt_t'(AFULL_THRESH);
   localparam cnt_t AEMPTY_LVL = cnt_t'(AEMPTY_THRESH);
   localparam cnt_t CNT_ONE    = cnt_t'(1);
   localparam addr_t PTR_ONE   = addr_t'(1);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   addr_t wr_ptr;
   addr_t rd_ptr;
   logic  wr_acc;

   assign full_o   = (count_o == DEPTH_LVL);
   assign afull_o  = (count_o >= AFULL_LVL);
   assign aempty_o = (count_o <= AEMPTY_LVL);
   assign wr_acc   = wr_en_i && !full_o;

   // NOTE: the storage array has no reset so it maps onto block RAM; the pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (wr_acc) mem[wr_ptr] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)       wr_ptr <= '0;
      else if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
   end

   generate
      if (FWFT == 0) begin : g_std
         logic rd_acc;
         assign rd_acc  = rd_en_i && (count_o != '0);
         assign empty_o = (count_o == '0);

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rd_ptr    <= '0;
               count_o   <= '0;
               rd_data_o <= '0;
            end else begin
               if (rd_acc) begin
                  rd_data_o <= mem[rd_ptr];
                  rd_ptr    <= rd_ptr + PTR_ONE;
               end
               case ({wr_acc, rd_acc})
                  2'b10:   count_o <= count_o + CNT_ONE;
                  2'b01:   count_o <= count_o - CNT_ONE;
                  default: count_o <= count_o;
               endcase
            end
         end
      end else begin : g_fwft
         // rd_data_o is prefetch entry 0 (the head); pf_data1 is entry 1 behind it.
         cnt_t                  ram_cnt;
         logic [1:0]            pf_cnt;
         logic [1:0]            pf_cnt_shift;
         logic [DATA_WIDTH-1:0] pf_data1;
         logic                  pop;
         logic                  ram_ld;

         assign empty_o      = (pf_cnt == 2'd0);
         assign pop          = rd_en_i && !empty_o;
         assign pf_cnt_shift = pf_cnt - {1'b0, pop};
         assign ram_ld       = (ram_cnt != '0) && (pf_cnt_shift != 2'd2);

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rd_ptr    <= '0;
               count_o   <= '0;
               ram_cnt   <= '0;
               pf_cnt    <= '0;
               pf_data1  <= '0;
               rd_data_o <= '0;
            end else begin
               if (pop && (pf_cnt == 2'd2)) rd_data_o <= pf_data1;
               if (ram_ld) begin
                  rd_ptr <= rd_ptr + PTR_ONE;
                  if (pf_cnt_shift == 2'd0) rd_data_o <= mem[rd_ptr];
                  else                      pf_data1  <= mem[rd_ptr];
               end
               pf_cnt <= pf_cnt_shift + {1'b0, ram_ld};
               case ({wr_acc, ram_ld})
                  2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                  2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                  default: ram_cnt <= ram_cnt;
               endcase
               case ({wr_acc, pop})
                  2'b10:   count_o <= count_o + CNT_ONE;
                  2'b01:   count_o <= count_o - CNT_ONE;
                  default: count_o <= count_o;
               endcase
            end
         end
      end
   endgenerate

`ifdef SFIFO_ERR_FLAG_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wr_en_i && full_o)  overflow_o  <= 1'b1;
         if (rd_en_i && empty_o) underflow_o <= 1'b1;
      end
   end
`else
   assign overflow_o  = 1'b0;
   assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_mem_ctrl.sv
// Directed bench for sfifo_mem_ctrl: one standard-mode and one FWFT instance on a shared clock/reset.
module tb_sfifo_mem_ctrl;

`ifdef SFIFO_ERR_FLAG_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       s_wr_en = 1'b0, s_rd_en = 1'b0;
   logic [7:0] s_wr_data = '0, s_rd_data;
   logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
   logic [4:0] s_count;

   logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
   logic [7:0] f_wr_data = '0, f_rd_data;
   logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
   logic [4:0] f_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sfifo_mem_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_std (
      .clk_i(clk), .rst_i(rst), .wr_en_i(s_wr_en), .wr_data_i(s_wr_data), .full_o(s_full),
      .afull_o(s_afull), .rd_en_i(s_rd_en), .rd_data_o(s_rd_data), .empty_o(s_empty),
      .aempty_o(s_aempty), .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_unf)
   );

   sfifo_mem_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_fwft (
      .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr_en), .wr_data_i(f_wr_data), .full_o(f_full),
      .afull_o(f_afull), .rd_en_i(f_rd_en), .rd_data_o(f_rd_data), .empty_o(f_empty),
      .aempty_o(f_aempty), .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // T1: reset held two cycles while writes are requested
      rst = 1'b1; s_wr_en = 1'b1; s_wr_data = 8'h55; f_wr_en = 1'b1; f_wr_data = 8'h66;
      tick(); tick();
      rst = 1'b0; s_wr_en = 1'b0; f_wr_en = 1'b0;
      check("rst_s_empty", s_empty, 1);
      check("rst_s_aempty", s_aempty, 1);
      check("rst_s_full", s_full, 0);
      check("rst_s_afull", s_afull, 0);
      check("rst_s_count", s_count, 0);
      check("rst_s_rd_data", s_rd_data, 8'h00);
      check("rst_s_ovf", s_ovf, 0);
      check("rst_s_unf", s_unf, 0);
      check("rst_f_empty", f_empty, 1);
      check("rst_f_count", f_count, 0);
      check("rst_f_rd_data", f_rd_data, 8'h00);

      // T2: fill 0x00..0x0F, then drain in order
      for (int i = 0; i < 16; i++) begin
         s_wr_en = 1'b1; s_wr_data = 8'(i);
         tick();
         check("fill_count", s_count, i + 1);
         check("fill_afull", s_afull, (i + 1 >= 12));
         check("fill_full", s_full, (i + 1 == 16));
         check("fill_empty", s_empty, 0);
      end
      s_wr_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_rd_en = 1'b1;
         tick();
         check("drain_data", s_rd_data, i);
         check("drain_count", s_count, 15 - i);
         check("drain_aempty", s_aempty, (15 - i <= 4));
         check("drain_empty", s_empty, (i == 15));
         check("drain_full", s_full, 0);
      end
      s_rd_en = 1'b0;
      tick();
      check("hold_data", s_rd_data, 8'h0F);

      // T6 standard: read while empty is ignored
      s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      check("s_emptyrd_count", s_count, 0);
      check("s_emptyrd_data", s_rd_data, 8'h0F);
      check("s_underflow", s_unf, ERR_EN);

      // T3: three rounds of write 10 / read 10 across the pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 10; j++) begin
            s_wr_en = 1'b1; s_wr_data = 8'(8'h30 + r * 10 + j);
            tick();
         end
         s_wr_en = 1'b0;
         check("wrap_count", s_count, 10);
         for (int j = 0; j < 10; j++) begin
            s_rd_en = 1'b1;
            tick();
            check("wrap_data", s_rd_data, 8'h30 + r * 10 + j);
         end
         s_rd_en = 1'b0;
         check("wrap_empty", s_empty, 1);
      end

      // Simultaneous write and read at count 1 returns the older word
      s_wr_en = 1'b1; s_wr_data = 8'h77;
      tick();
      s_wr_data = 8'h88; s_rd_en = 1'b1;
      tick();
      check("wr_rd_c1_count", s_count, 1);
      check("wr_rd_c1_data", s_rd_data, 8'h77);
      s_wr_en = 1'b0;
      tick();
      s_rd_en = 1'b0;
      check("wr_rd_c1_next", s_rd_data, 8'h88);
      check("wr_rd_c1_empty", s_empty, 1);

      // T4: at full, write+read together -> write dropped, read accepted
      for (int i = 0; i < 16; i++) begin
         s_wr_en = 1'b1; s_wr_data = 8'(8'h40 + i);
         tick();
      end
      check("t4_full", s_full, 1);
      check("t4_ovf_before", s_ovf, 0);
      s_wr_data = 8'hEE; s_rd_en = 1'b1;
      tick();
      s_wr_en = 1'b0; s_rd_en = 1'b0;
      check("t4_count", s_count, 15);
      check("t4_data", s_rd_data, 8'h40);
      check("t4_overflow", s_ovf, ERR_EN);
      for (int i = 1; i < 16; i++) begin
         s_rd_en = 1'b1;
         tick();
         check("t4_drain", s_rd_data, 8'h40 + i);
      end
      s_rd_en = 1'b0;
      check("t4_empty", s_empty, 1);

      // T5: FWFT latency -- write at N, head visible at N+2
      f_wr_en = 1'b1; f_wr_data = 8'hA5;
      tick();
      f_wr_en = 1'b0;
      check("fwft_n1_empty", f_empty, 1);
      check("fwft_n1_count", f_count, 1);
      tick();
      check("fwft_n2_empty", f_empty, 0);
      check("fwft_n2_data", f_rd_data, 8'hA5);
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      check("fwft_pop_empty", f_empty, 1);
      check("fwft_pop_count", f_count, 0);
      check("fwft_pop_hold", f_rd_data, 8'hA5);

      // T5: eight queued words popped back to back without a bubble
      for (int i = 0; i < 8; i++) begin
         f_wr_en = 1'b1; f_wr_data = 8'(8'h10 + i);
         tick();
      end
      f_wr_en = 1'b0;
      tick(); tick();
      check("fwft_q_count", f_count, 8);
      check("fwft_q_head", f_rd_data, 8'h10);
      check("fwft_q_empty", f_empty, 0);
      for (int k = 1; k <= 8; k++) begin
         f_rd_en = 1'b1;
         tick();
         check("fwft_stream_count", f_count, 8 - k);
         check("fwft_stream_empty", f_empty, (k == 8));
         if (k < 8) check("fwft_stream_data", f_rd_data, 8'h10 + k);
      end
      f_rd_en = 1'b0;
      check("fwft_stream_hold", f_rd_data, 8'h17);

      // T6 FWFT: pop while empty is ignored
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      check("f_emptyrd_count", f_count, 0);
      check("f_emptyrd_data", f_rd_data, 8'h17);
      check("f_underflow", f_unf, ERR_EN);
      check("f_overflow", f_ovf, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
